inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction supplier for the single-cycle NPC core. Owns the PC, issues one
//  instruction-memory read at a time over a valid/ready request channel, accepts
//  the response, and presents {inst, pc} to the core through a valid/ready
//  output. Execute-stage redirects (branch/jump) change the PC and squash the
//  in-flight fetch.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  read address (word aligned)
//  imem_rsp_valid  in   1   read data valid (one pulse per accepted request)
//  imem_rsp_data   in   32  read data
//  redirect_valid  in   1   execute redirects fetch this cycle
//  redirect_pc     in   32  new PC; bits [1:0] ignored (forced 2'b00)
//  out_valid       out  1   {out_inst, out_pc} valid to core
//  out_ready       in   1   core consumes instruction
//  out_inst        out  32  fetched instruction
//  out_pc          out  32  address of out_inst
// BEHAVIOUR
//  - Reset state (rst high): state=REQ, pc=RESET_PC, drop=0, out_inst=0,
//    out_pc=0, out_valid=0. imem_req_valid is 0 while rst is high and is 1 in
//    the first cycle after rst falls.
//  - One outstanding request max. imem_req_addr = pc. pc wraps mod 2^32.
//  - States:
//     REQ : imem_req_valid=1. On req handshake -> WAIT.
//     WAIT: wait for imem_rsp_valid. On rsp: if drop, discard data, clear drop,
//           -> REQ; else capture out_inst<=data, out_pc<=pc -> HOLD.
//     HOLD: out_valid=1, outputs stable. On out handshake: pc<=pc+4 -> REQ.
//  - Output latency: req handshake cycle t, rsp in cycle t+k (k>=1),
//    out_valid high from cycle t+k+1. out_valid is registered (HOLD only).
//  - Redirect (highest priority over pc update; pc<=redirect_pc&~3):
//     REQ, no handshake same cycle : stay REQ, addr changes next cycle (only
//           permitted change of addr while req_valid=1 and not accepted).
//     REQ, handshake same cycle    : -> WAIT with drop=1.
//     WAIT, no rsp same cycle      : drop<=1, stay WAIT.
//     WAIT, rsp same cycle         : rsp discarded, drop<=0, -> REQ.
//     HOLD                         : out_valid drops next cycle, -> REQ. If
//           out_ready was also high, the handshake counts (core took it) and
//           the redirect pc still wins over pc+4.
//  - imem_rsp_valid outside WAIT is ignored (no state change).
//  - Reset mid-operation: all state returns to reset values next cycle; a
//    response for a pre-reset request arriving in REQ is ignored by the above.
//  - out_inst/out_pc hold last captured value when out_valid=0.
// TESTING
//  1 Reset, imem ready=1, rsp 1 cycle later with data=0x00100093, out_ready=1
//    -> first req_addr=0x80000000, out_valid/out_pc=0x80000000, next req 0x80000004.
//  2 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid stays 1,
//    out_inst/out_pc stable, no new imem request issued.
//  3 imem_req_ready low 3 cycles -> req_valid held 1, addr stable; accepted on
//    cycle 4, exactly one response consumed.
//  4 Redirect to 0x80000103 during WAIT -> stale rsp dropped (out_valid stays 0),
//    next req_addr=0x80000100, its data presented with out_pc=0x80000100.
//  5 Redirect coincident with rsp in WAIT and with out handshake in HOLD -> rsp
//    discarded / handshake counted; next req_addr = redirect_pc in both cases.
//  6 pc=0xFFFFFFFC consumed -> next req_addr=0x00000000; rst asserted in WAIT ->
//    next cycle req_valid=0, out_valid=0, then req_addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit for the single-cycle NPC core.
// Owns the PC, issues at most one instruction-memory read at a time, captures
// the response and presents {inst, pc} to the core over a valid/ready output.
// Execute-stage redirects replace the PC and squash any in-flight fetch.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr      instruction read request channel
//   imem_rsp_valid/data            read response (one pulse per accepted request)
//   redirect_valid/pc              branch/jump redirect from execute
//   out_valid/ready/inst/pc        fetched instruction to the core
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   opc_q, opc_d;

  logic              req_hs;
  logic              out_hs;
  logic [XLEN-1:0]   redirect_aligned;

  assign req_hs           = imem_req_valid && imem_req_ready;
  assign out_hs           = out_valid && out_ready;
  assign redirect_aligned = redirect_pc & ~XLEN'(32'h3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
    end
  end

  // Next-state and datapath update; redirect always wins the PC
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    opc_d   = opc_q;

    unique case (state_q)
      S_REQ: begin
        if (req_hs) begin
          state_d = S_WAIT;
          // Request already went out with the old PC: its data must be dropped
          drop_d  = redirect_valid;
        end
        if (redirect_valid) begin
          pc_d = redirect_aligned;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            opc_d   = pc_q;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_aligned;
          state_d = S_REQ;
        end else if (out_hs) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Control outputs decoded from the state register
  always_comb begin
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    // Gate with rst so no request is offered while reset is held
    if (state_q == S_REQ) begin
      imem_req_valid = !rst;
    end
    if (state_q == S_HOLD) begin
      out_valid = 1'b1;
    end
  end

  assign imem_req_addr = pc_q;
  assign out_inst      = inst_q;
  assign out_pc        = opc_q;

endmodule
